lz_normalizer: RTL

//  Downstream consumer of the leading-zero counter in the ALU datapath. Takes an operand and its

---
 rtl/lz_normalizer_if.sv | 44 ++++
 rtl/lz_normalizer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lz_normalizer_if.sv
// Operand/result stream bundle for lz_normalizer: master drives operands and consumes results,
// slave is the normalizer. Exponent signals are present only when LZN_EXP_EN is defined.
interface lz_normalizer_if #(
  parameter int DATAWIDTH = 32,
  parameter int SW        = $clog2(DATAWIDTH) + 1
`ifdef LZN_EXP_EN
  , parameter int EW      = 8
`endif
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic [DATAWIDTH-1:0] in_cnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic [SW-1:0]        out_shamt;
  logic                 out_zero;
`ifdef LZN_EXP_EN
  logic [EW-1:0]        in_exp;
  logic [EW-1:0]        out_exp;
  logic                 out_uf;

  modport master (
    output in_valid, in_data, in_cnt, in_exp, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_zero, out_exp, out_uf
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_exp, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_zero, out_exp, out_uf
  );
`else
  modport master (
    output in_valid, in_data, in_cnt, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_cnt, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_zero
  );
`endif
endinterface

// File: rtl/lz_normalizer.sv
// Two-stage normalizer: shifts an operand left by its (saturated) leading-zero count.
// Optional exponent adjust and underflow flag are built when LZN_EXP_EN is defined.
module lz_normalizer #(
  parameter int DATAWIDTH = 32,
  parameter int SW        = $clog2(DATAWIDTH) + 1
`ifdef LZN_EXP_EN
  , parameter int EW      = 8
`endif
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  lz_normalizer_if.slave   bus
);

  localparam logic [DATAWIDTH-1:0] CNT_MAX = DATAWIDTH'(DATAWIDTH);
  localparam logic [SW-1:0]        SH_MAX  = SW'(DATAWIDTH);

  // Handshake: an item moves on valid && ready at a rising edge. Stage 2 can take a new
  // item when it is empty or its result is being consumed (adv2); stage 1 can accept when
  // empty or draining into stage 2. flush blocks acceptance for that cycle.
  logic                 v1;
  logic                 v2;
  logic [DATAWIDTH-1:0] d1;
  logic [SW-1:0]        c1;

  logic                 adv2;
  logic                 acc;
  logic [SW-1:0]        cnt_sat;
  logic [DATAWIDTH-1:0] shifted;
  logic                 is_zero;

  logic [DATAWIDTH-1:0] out_data_q;
  logic [SW-1:0]        out_shamt_q;
  logic                 out_zero_q;

  assign adv2         = !v2 || bus.out_ready;
  assign bus.in_ready = (!v1 || adv2) && !flush;
  assign acc          = bus.in_valid && bus.in_ready;

  always_comb begin
    cnt_sat = SW'(bus.in_cnt);
    if (bus.in_cnt > CNT_MAX) begin
      cnt_sat = SH_MAX;
    end
  end

  // A full-width shift would be out of range for the shifter; it yields zero.
  always_comb begin
    shifted = d1 << c1;
    if (c1 >= SH_MAX) begin
      shifted = '0;
    end
  end

  assign is_zero = (d1 == '0);

`ifdef LZN_EXP_EN
  localparam int XW = (EW > SW) ? EW : SW;

  logic [EW-1:0] e1;
  logic [XW-1:0] e_ext;
  logic [XW-1:0] c_ext;
  logic          uf_raw;
  logic [EW-1:0] exp_next;
  logic          uf_next;
  logic [EW-1:0] out_exp_q;
  logic          out_uf_q;

  assign e_ext  = XW'(e1);
  assign c_ext  = XW'(c1);
  assign uf_raw = (e_ext < c_ext);

  // A zero operand has no meaningful exponent, so it never reports underflow.
  always_comb begin
    exp_next = EW'(e_ext - c_ext);
    uf_next  = 1'b0;
    if (is_zero) begin
      exp_next = '0;
    end else if (uf_raw) begin
      exp_next = '0;
      uf_next  = 1'b1;
    end
  end
`endif

  // Stage 1: capture operand and saturated count.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      c1 <= '0;
`ifdef LZN_EXP_EN
      e1 <= '0;
`endif
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (acc) begin
      v1 <= 1'b1;
      d1 <= bus.in_data;
      c1 <= cnt_sat;
`ifdef LZN_EXP_EN
      e1 <= bus.in_exp;
`endif
    end else if (v1 && adv2) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: register the normalized result; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2          <= 1'b0;
      out_data_q  <= '0;
      out_shamt_q <= '0;
      out_zero_q  <= 1'b0;
`ifdef LZN_EXP_EN
      out_exp_q   <= '0;
      out_uf_q    <= 1'b0;
`endif
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data_q  <= shifted;
        out_shamt_q <= c1;
        out_zero_q  <= is_zero;
`ifdef LZN_EXP_EN
        out_exp_q   <= exp_next;
        out_uf_q    <= uf_next;
`endif
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_data  = out_data_q;
  assign bus.out_shamt = out_shamt_q;
  assign bus.out_zero  = out_zero_q;
`ifdef LZN_EXP_EN
  assign bus.out_exp   = out_exp_q;
  assign bus.out_uf    = out_uf_q;
`endif

endmodule
